// File: rtl/ps2_entry_buffer.sv
// ps2_entry_buffer
// Capture stage ahead of the AES message/key buffers. It parses the raw PS/2
// byte stream (make, F0 break and E0 extended prefixes) and commits one
// scancode per completed key release into a DEPTH-byte shift buffer. The
// newest byte sits in buf_out[7:0]. Backspace removes the newest byte, enter
// raises done_pulse, and the shift keys are ignored. All outputs are registered
// and update on the edge that samples the key_pressed strobe.

module ps2_entry_buffer #(
    parameter int          DEPTH      = 16,
    parameter logic [7:0]  BKSP_CODE  = 8'h66,
    parameter logic [7:0]  ENTER_CODE = 8'h5A,
    localparam int         CW         = $clog2(DEPTH + 1),
    localparam int         BW         = 8 * DEPTH
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [7:0]    key_data,
    input  logic          key_pressed,
    input  logic          enable,
    input  logic          clear,
    output logic [BW-1:0] buf_out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow,
    output logic          commit_pulse,
    output logic          done_pulse
);

    // PS/2 prefix tracker. EXT_BREAK swallows the byte after E0 F0 so that
    // extended keys (arrows, keypad enter, ...) never reach the buffer.
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_EXT_BREAK,
        S_BREAK
    } state_t;

    // What a release event does to the buffer in this cycle.
    typedef enum logic [2:0] {
        A_NONE,
        A_DONE,
        A_PUSH,
        A_POP,
        A_OVERFLOW
    } action_t;

    localparam logic [7:0]    BREAK_PREFIX = 8'hF0;
    localparam logic [7:0]    EXT_PREFIX   = 8'hE0;
    localparam logic [7:0]    LSHIFT_CODE  = 8'h12;
    localparam logic [7:0]    RSHIFT_CODE  = 8'h59;
    localparam logic [CW-1:0] COUNT_MAX    = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_LAST   = CW'(DEPTH - 1);

    state_t  state;
    action_t action;
    logic    release_event;

    // A release is the byte that follows a plain F0 prefix.
    assign release_event = key_pressed && (state == S_BREAK);

    // Decode the buffer action for the byte being released.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        action = A_NONE;
        if (release_event && enable) begin
            if (key_data == ENTER_CODE) begin
                action = A_DONE;
            end else if (key_data == BKSP_CODE) begin
                if (count != '0) begin
                    action = A_POP;
                end
            end else if ((key_data == LSHIFT_CODE) || (key_data == RSHIFT_CODE)) begin
                action = A_NONE;
            end else if (count == COUNT_MAX) begin
                action = A_OVERFLOW;
            end else begin
                action = A_PUSH;
            end
        end
    end

    // Prefix FSM, buffer, count and status strobes, all registered.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement
    // order and simulation matches the synthesised flops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            buf_out      <= '0;
            count        <= '0;
            full         <= 1'b0;
            overflow     <= 1'b0;
            commit_pulse <= 1'b0;
            done_pulse   <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            done_pulse   <= 1'b0;

            // The prefix tracker runs even while disabled or clearing so it
            // never loses sync with the keyboard stream.
            if (key_pressed) begin
                case (state)
                    S_IDLE: begin
                        if (key_data == BREAK_PREFIX) begin
                            state <= S_BREAK;
                        end else if (key_data == EXT_PREFIX) begin
                            state <= S_EXT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_EXT: begin
                        if (key_data == BREAK_PREFIX) begin
                            state <= S_EXT_BREAK;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_EXT_BREAK: state <= S_IDLE;
                    S_BREAK:     state <= S_IDLE;
                    default:     state <= S_IDLE;
                endcase
            end

            // Clear wins over a simultaneous release and suppresses its pulses.
            if (clear) begin
                buf_out  <= '0;
                count    <= '0;
                full     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (action)
                    A_DONE: begin
                        done_pulse <= 1'b1;
                    end
                    A_POP: begin
                        buf_out      <= {8'h00, buf_out[BW-1:8]};
                        count        <= count - 1'b1;
                        full         <= 1'b0;
                        commit_pulse <= 1'b1;
                    end
                    A_PUSH: begin
                        buf_out      <= {buf_out[BW-9:0], key_data};
                        count        <= count + 1'b1;
                        full         <= (count == COUNT_LAST);
                        commit_pulse <= 1'b1;
                    end
                    A_OVERFLOW: begin
                        overflow <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_entry_buffer.sv
// tb_ps2_entry_buffer
// Directed bench for ps2_entry_buffer. A behavioural model keeps the buffer
// as a byte queue; every driven cycle pushes the model's expected outputs to a
// scoreboard, which is popped and compared one cycle later after the edge.

module tb_ps2_entry_buffer;

    typedef struct {
        string        tag;
        logic [127:0] buf_v;
        logic [4:0]   count_v;
        logic         full_v;
        logic         ovf_v;
        logic         commit_v;
        logic         done_v;
    } exp_t;

    logic         clock;
    logic         resetn;
    logic [7:0]   key_data;
    logic         key_pressed;
    logic         enable;
    logic         clear;
    logic [127:0] buf_out;
    logic [4:0]   count;
    logic         full;
    logic         overflow;
    logic         commit_pulse;
    logic         done_pulse;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    // model state: 0 idle, 1 ext, 2 ext-break, 3 break
    int         m_state;
    logic [7:0] m_bytes[$];
    logic       m_ovf;

    ps2_entry_buffer dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_data     (key_data),
        .key_pressed  (key_pressed),
        .enable       (enable),
        .clear        (clear),
        .buf_out      (buf_out),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .commit_pulse (commit_pulse),
        .done_pulse   (done_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_buf();
        logic [127:0] r;
        int n;
        r = '0;
        n = m_bytes.size();
        for (int i = 0; i < n; i++) begin
            r[8*i +: 8] = m_bytes[n-1-i];
        end
        return r;
    endfunction

    task automatic push_exp(input string tag, input logic cp, input logic dp);
        exp_t e;
        e.tag      = tag;
        e.buf_v    = model_buf();
        e.count_v  = 5'(m_bytes.size());
        e.full_v   = (m_bytes.size() == 16);
        e.ovf_v    = m_ovf;
        e.commit_v = cp;
        e.done_v   = dp;
        sb.push_back(e);
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input string tag, input logic [7:0] b, input logic kp,
                              input logic en, input logic clr);
        logic rel;
        logic cp;
        logic dp;
        rel = kp && (m_state == 3);
        cp  = 1'b0;
        dp  = 1'b0;
        if (kp) begin
            if (m_state == 0)      m_state = (b == 8'hF0) ? 3 : (b == 8'hE0) ? 1 : 0;
            else if (m_state == 1) m_state = (b == 8'hF0) ? 2 : 0;
            else                   m_state = 0;
        end
        if (clr) begin
            m_bytes.delete();
            m_ovf = 1'b0;
        end else if (rel && en) begin
            if (b == 8'h5A) begin
                dp = 1'b1;
            end else if (b == 8'h66) begin
                if (m_bytes.size() > 0) begin
                    void'(m_bytes.pop_back());
                    cp = 1'b1;
                end
            end else if (b != 8'h12 && b != 8'h59) begin
                if (m_bytes.size() < 16) begin
                    m_bytes.push_back(b);
                    cp = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        push_exp(tag, cp, dp);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: got empty queue want an entry");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".buf"},    buf_out,        e.buf_v);
        check({e.tag, ".count"},  128'(count),    128'(e.count_v));
        check({e.tag, ".full"},   128'(full),     128'(e.full_v));
        check({e.tag, ".ovf"},    128'(overflow), 128'(e.ovf_v));
        check({e.tag, ".commit"}, 128'(commit_pulse), 128'(e.commit_v));
        check({e.tag, ".done"},   128'(done_pulse),   128'(e.done_v));
    endtask

    // One clock with the given inputs; outputs compared #1 after the edge.
    task automatic cycle(input string tag, input logic [7:0] b, input logic kp,
                         input logic en, input logic clr);
        @(negedge clock);
        key_data    = b;
        key_pressed = kp;
        enable      = en;
        clear       = clr;
        model_step(tag, b, kp, en, clr);
        @(posedge clock);
        #1;
        key_pressed = 1'b0;
        clear       = 1'b0;
        compare_next();
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        cycle(tag, b, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic release_key(input string tag, input logic [7:0] b);
        send(tag, 8'hF0);
        send(tag, b);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 8'h00, 1'b0, enable, 1'b0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clock);
        resetn      = 1'b0;
        key_pressed = 1'b0;
        clear       = 1'b0;
        m_state     = 0;
        m_bytes.delete();
        m_ovf       = 1'b0;
        push_exp(tag, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        compare_next();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        key_data    = 8'h00;
        key_pressed = 1'b0;
        enable      = 1'b1;
        clear       = 1'b0;
        m_state     = 0;
        m_ovf       = 1'b0;

        // reset state
        apply_reset("reset");

        // make 1C is ignored, release 1C commits
        send("make1c", 8'h1C);
        send("f0", 8'hF0);
        send("rel1c", 8'h1C);
        check("t1.low", 128'(buf_out[7:0]), 128'(8'h1C));
        check("t1.count", 128'(count), 128'(5'd1));
        check("t1.commit", 128'(commit_pulse), 128'(1'b1));
        idle("t1.pulse_end");
        check("t1.commit_off", 128'(commit_pulse), 128'(1'b0));

        // three releases then backspace
        cycle("clr2", 8'h00, 1'b0, 1'b1, 1'b1);
        release_key("rel", 8'h1C);
        release_key("rel", 8'h32);
        release_key("rel", 8'h21);
        release_key("bksp", 8'h66);
        check("t2.low", 128'(buf_out[15:0]), 128'(16'h1C32));
        check("t2.count", 128'(count), 128'(5'd2));
        check("t2.high", 128'(buf_out[127:16]), 128'(0));

        // fill to 16 then overflow
        cycle("clr3", 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            release_key("fill", 8'(8'h15 + i));
        end
        release_key("ovf", 8'h2D);
        check("t3.full", 128'(full), 128'(1'b1));
        check("t3.ovf", 128'(overflow), 128'(1'b1));
        check("t3.count", 128'(count), 128'(5'd16));
        check("t3.low", 128'(buf_out[7:0]), 128'(8'h24));
        check("t3.nocommit", 128'(commit_pulse), 128'(1'b0));

        // extended release and shift release change nothing
        send("ext", 8'hE0);
        send("ext", 8'hF0);
        send("ext", 8'h75);
        release_key("shift", 8'h12);
        check("t4.count", 128'(count), 128'(5'd16));

        // enter with count 3, then clear colliding with a release
        cycle("clr5", 8'h00, 1'b0, 1'b1, 1'b1);
        release_key("rel", 8'h1C);
        release_key("rel", 8'h1B);
        release_key("rel", 8'h23);
        release_key("enter", 8'h5A);
        check("t5.done", 128'(done_pulse), 128'(1'b1));
        check("t5.count", 128'(count), 128'(5'd3));
        idle("t5.done_end");
        send("t5.f0", 8'hF0);
        cycle("t5.clr_rel", 8'h1C, 1'b1, 1'b1, 1'b1);
        check("t5.clr_count", 128'(count), 128'(5'd0));
        check("t5.clr_commit", 128'(commit_pulse), 128'(1'b0));
        send("t5.make_after", 8'h1C);

        // disabled release is dropped but the FSM stays in sync
        cycle("dis.f0", 8'hF0, 1'b1, 1'b0, 1'b0);
        cycle("dis.1c", 8'h1C, 1'b1, 1'b0, 1'b0);
        cycle("en.f0", 8'hF0, 1'b1, 1'b1, 1'b0);
        cycle("en.2c", 8'h2C, 1'b1, 1'b1, 1'b0);
        check("t6.count", 128'(count), 128'(5'd1));
        check("t6.low", 128'(buf_out[7:0]), 128'(8'h2C));

        // reset after F0: next byte is a make code
        send("pre_rst.f0", 8'hF0);
        apply_reset("mid_reset");
        send("post_rst.1c", 8'h1C);
        check("t7.count", 128'(count), 128'(5'd0));
        check("t7.commit", 128'(commit_pulse), 128'(1'b0));
        idle("t7.idle");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_entry_buffer.md
Name: ps2_entry_buffer

Overview:
- Upstream capture stage that feeds the 128-bit message/key buffers consumed by the AES key expansion and cipher.
- Parses the raw PS/2 byte stream from the keyboard controller: make, break (F0) and extended (E0) prefixes.
- Commits one scancode per completed key release into a 16-byte shift buffer, with backspace, enter and clear handling.
- Provides a fill count and status strobes for the display and control logic.

Parameters:
- DEPTH, 16, buffer depth in bytes; buffer width is 8*DEPTH.
- BKSP_CODE, 8'h66, scancode that deletes the last committed byte.
- ENTER_CODE, 8'h5A, scancode that raises done_pulse and is never stored.

Ports:
- clock  input  1  system clock (50 MHz); all state is on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- key_data  input  8  byte from the PS/2 interface.
- key_pressed  input  1  one-cycle strobe; key_data is valid in the same cycle.
- enable  input  1  buffer is selected; when low, commits are suppressed.
- clear  input  1  synchronous clear of buffer, count and overflow.
- buf_out  output  128  buffer; the newest byte is in [7:0].
- count  output  5  number of valid bytes (0..16).
- full  output  1  high when count==16.
- overflow  output  1  sticky; set when a commit is attempted while full.
- commit_pulse  output  1  one-cycle strobe when a byte is stored or removed.
- done_pulse  output  1  one-cycle strobe on release of ENTER_CODE.

Behaviour:
- Reset, asynchronous on resetn low: buf_out=0, count=0, full=0, overflow=0, commit_pulse=0, done_pulse=0, FSM=IDLE.
- All outputs are registered. The effect of a key_pressed strobe is visible on the next rising edge (1-cycle latency).
- FSM (advances only on key_pressed):
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte (make or typematic repeat) -> IDLE with no action.
  - EXT: F0 -> EXT_BREAK; any other byte -> IDLE.
  - EXT_BREAK: any byte -> IDLE; extended keys are never committed.
  - BREAK: byte b -> IDLE and a release event with code b.
- Release event, only when enable=1:
  - b==ENTER_CODE: done_pulse=1; buffer unchanged.
  - b==BKSP_CODE with count>0: buf_out shifts right by 8 with zero fill in [127:120]; count-1; commit_pulse=1.
  - b==BKSP_CODE with count==0: no change and no pulse.
  - b is 8'h12 or 8'h59 (shift keys): ignored.
  - Any other b with count<16: buf_out = {buf_out[119:0], b}; count+1; commit_pulse=1.
  - Any other b with count==16: buffer unchanged; overflow=1; no commit_pulse.
- When enable=0, the FSM keeps tracking prefixes so it stays synchronised, but release events cause no buffer change and no pulses.
- clear=1: buf_out=0, count=0, overflow=0 on the next edge. The FSM state is kept.
- Clear has priority over a simultaneous release event, and pulses are suppressed in that cycle.
- full is derived registered: it equals (count==16) after each update.
- key_pressed with a byte arriving while clear=1 still advances the FSM.
- Reset asserted mid-sequence, for example after F0: the FSM returns to IDLE, so the next byte is treated as a make code.

Test Plan:
- Reset, then the sequence 1C, F0, 1C -> after the last strobe: buf_out[7:0]=1C, count=1, commit_pulse high for exactly one cycle.
- Release 1C, 32, 21 in turn, then F0 66 -> buf_out[15:0]=1C32, count=2, buf_out[127:16]=0.
- Release 16 bytes 0x15..0x24, then release 2D -> full=1, overflow=1, count=16, buf_out[7:0]=24, no commit_pulse on the 17th.
- Sequence E0, F0, 75 (up arrow release) and F0 12 (shift release) -> buf_out and count unchanged, no pulses.
- F0 5A with count=3 -> done_pulse for one cycle, count=3. Then clear asserted in the same cycle as F0 1C completes -> count=0, buf_out=0, commit_pulse=0.
- enable=0 during F0 1C, then enable=1 during F0 2C -> only 2C is stored (count=1). Assert resetn low after F0, then send 1C -> no commit.
